serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 27 ++
 rtl/full_subtractor.sv | 26 ++
 rtl/serial_subtractor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared definitions for the bit-serial subtractor: default
//               operand width, FSM state encodings and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  // Default operand / result width in bits.
  localparam int DEFAULT_WIDTH = 4;

  // FSM state encodings.
  localparam int         STATE_W  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // The bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor, A - B - B_in, producing a difference
//               bit and a borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic B_in,
  output logic Diff,
  output logic B_out
);

  // Difference is odd parity; a borrow is needed when the minuend bit is 0
  // and anything is subtracted, or when both subtrahend and borrow are 1.
  always_comb begin
    Diff  = A ^ B ^ B_in;
    B_out = (~A & (B | B_in)) | (B & B_in);
  end

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor. Computes (A - B - B_in) mod
//               2^WIDTH one bit per clock, LSB first, and reports the final
//               borrow. A three-state FSM (IDLE / SHIFT / DONE) sequences the
//               operation; results are registered and held between runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic [WIDTH-1:0] Diff,
  output logic             B_out,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Sequencer state and datapath registers.
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   res_q,   res_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   diff_q,  diff_d;
  logic               bout_q,  bout_d;

  // One-bit slice outputs for the current LSB position.
  logic fs_diff;
  logic fs_bout;

  full_subtractor u_fs (
    .A     (a_q[0]),
    .B     (b_q[0]),
    .B_in  (borrow_q),
    .Diff  (fs_diff),
    .B_out (fs_bout)
  );

  // Next-state and datapath control. SHIFT spends WIDTH cycles consuming
  // operand bits; once the counter reaches WIDTH a final SHIFT cycle commits
  // the result to the output registers as the FSM moves into DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = B_in;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != CNT_END) begin
          a_d             = a_q >> 1;
          b_d             = b_q >> 1;
          res_d           = res_q >> 1;
          res_d[WIDTH-1]  = fs_diff;
          borrow_d        = fs_bout;
          cnt_d           = cnt_q + CNT_ONE;
        end else begin
          diff_d  = res_q;
          bout_d  = borrow_q;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous clear of everything, outputs included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  // Outputs are decoded purely from registers, so inputs never reach them
  // combinationally.
  always_comb begin
    Diff  = diff_q;
    B_out = bout_q;
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DONE);
  end

endmodule

`default_nettype wire
